processor_result_collector: RTL and testbench

- Collects detection results from NUM_CH parallel Viola-Jones window processors.
- Each processor presents valid, passfail, x, y and scale, and receives a taken acknowledge.
- The collector arbitrates round-robin, buffers accepted results in a DEPTH-entry FIFO, and streams them to the detection-output stage over a valid/ready port.
- Maintains saturating statistics counters; generalises the single-processor valid/passfail/taken result path to N channels with buffering and selectable fail forwarding.

---
 rtl/processor_result_collector_pkg.sv | 50 +++++
 rtl/processor_result_collector_fifo.sv | 68 ++++++
 rtl/processor_result_collector.sv | 170 +++++++++++++++++
 tb/tb_processor_result_collector.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/processor_result_collector_pkg.sv
// Shared types and helpers for the processor result collector: round-robin
// grant function, channel-index width derivation and the default result record.
package pkg_processorCollector;

  localparam int MAX_CH         = 16;
  localparam int DEF_ROW_BITS   = 10;
  localparam int DEF_COL_BITS   = 10;
  localparam int DEF_SCALE_BITS = 4;

  function automatic int ch_bits(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

  localparam int CH_BITS = ch_bits(MAX_CH);

  typedef struct packed {
    logic                      passfail;
    logic [DEF_ROW_BITS-1:0]   x;
    logic [DEF_COL_BITS-1:0]   y;
    logic [DEF_SCALE_BITS-1:0] scale;
    logic [CH_BITS-1:0]        ch;
  } result_t;

  // First set bit of valid at or after ptr, wrapping within num_ch channels.
  function automatic logic [MAX_CH-1:0] rrGrant(input logic [MAX_CH-1:0] valid,
                                                input logic [3:0]        ptr,
                                                input int                num_ch);
    logic [MAX_CH-1:0] grant;
    logic              found;
    int                idx;
    grant = 16'h0000;
    found = 1'b0;
    for (int k = 0; k < MAX_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= num_ch) begin
        idx = idx - num_ch;
      end else begin
        idx = idx;
      end
      if ((k < num_ch) && !found && valid[idx[3:0]]) begin
        grant[idx[3:0]] = 1'b1;
        found           = 1'b1;
      end else begin
        found = found;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/processor_result_collector_fifo.sv
// First-word fall-through result FIFO; the head reads as zero while empty.
module result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam logic [PTR_BITS-1:0] PTR_ONE  = PTR_BITS'(1);
  localparam logic [PTR_BITS:0]   CNT_ONE  = (PTR_BITS + 1)'(1);
  localparam logic [PTR_BITS:0]   CNT_FULL = (PTR_BITS + 1)'(DEPTH);

  logic [WIDTH-1:0]    mem_r [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr_r;
  logic [PTR_BITS-1:0] rd_ptr_r;
  logic [PTR_BITS:0]   count_r;
  logic                do_push_s;
  logic                do_pop_s;

  assign full      = (count_r == CNT_FULL);
  assign empty     = (count_r == {(PTR_BITS + 1){1'b0}});
  assign count     = count_r;
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Storage array; contents are meaningless once the pointers are reset.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PTR_BITS{1'b0}};
      rd_ptr_r <= {PTR_BITS{1'b0}};
      count_r  <= {(PTR_BITS + 1){1'b0}};
    end else begin
      wr_ptr_r <= do_push_s ? wr_ptr_r + PTR_ONE : wr_ptr_r;
      rd_ptr_r <= do_pop_s  ? rd_ptr_r + PTR_ONE : rd_ptr_r;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Head of queue, forced to zero when nothing is stored.
  always_comb begin
    if (empty) begin
      dout = {WIDTH{1'b0}};
    end else begin
      dout = mem_r[rd_ptr_r];
    end
  end

endmodule

// File: rtl/processor_result_collector.sv
// Round-robin collector of window-processor results into a FWFT output FIFO,
// with saturating evaluated/passed counters.
module processor_result_collector
  import pkg_processorCollector::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 8,
  parameter int ROW_BITS   = DEF_ROW_BITS,
  parameter int COL_BITS   = DEF_COL_BITS,
  parameter int SCALE_BITS = DEF_SCALE_BITS,
  parameter int FWD_FAILS  = 0,
  parameter int CNT_BITS   = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH-1:0]              ch_valid,
  input  logic [NUM_CH-1:0]              ch_passfail,
  input  logic [NUM_CH*ROW_BITS-1:0]     ch_x,
  input  logic [NUM_CH*COL_BITS-1:0]     ch_y,
  input  logic [NUM_CH*SCALE_BITS-1:0]   ch_scale,
  output logic [NUM_CH-1:0]              ch_taken,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_passfail,
  output logic [ROW_BITS-1:0]            out_x,
  output logic [COL_BITS-1:0]            out_y,
  output logic [SCALE_BITS-1:0]          out_scale,
  output logic [ch_bits(NUM_CH)-1:0]     out_ch,
  input  logic                           clear_stats,
  output logic [CNT_BITS-1:0]            cnt_evaluated,
  output logic [CNT_BITS-1:0]            cnt_passed,
  output logic                           idle
);

  localparam int LCH_BITS = ch_bits(NUM_CH);
  localparam int PTR_BITS = $clog2(DEPTH);
  localparam logic FWD_EN = (FWD_FAILS != 0);
  localparam logic [LCH_BITS-1:0] CH_LAST  = LCH_BITS'(NUM_CH - 1);
  localparam logic [LCH_BITS-1:0] CH_ONE   = LCH_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = {CNT_BITS{1'b1}};
  localparam logic [PTR_BITS:0]   CNT_FULL = (PTR_BITS + 1)'(DEPTH);

  typedef struct packed {
    logic                  passfail;
    logic [ROW_BITS-1:0]   x;
    logic [COL_BITS-1:0]   y;
    logic [SCALE_BITS-1:0] scale;
    logic [LCH_BITS-1:0]   ch;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  logic [LCH_BITS-1:0] ptr_r;
  logic [CNT_BITS-1:0] cnt_eval_r;
  logic [CNT_BITS-1:0] cnt_pass_r;
  logic [NUM_CH-1:0]   store_s;
  logic [NUM_CH-1:0]   elig_s;
  logic [NUM_CH-1:0]   grant_s;
  logic [MAX_CH-1:0]   elig_wide_s;
  logic [MAX_CH-1:0]   grant_wide_s;
  logic [LCH_BITS-1:0] gnt_idx_s;
  entry_t              push_entry_s;
  entry_t              head_s;
  logic [PTR_BITS:0]   fifo_count_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic                push_s;
  logic                pop_s;
  logic                xfer_s;
  logic                pass_xfer_s;

  // Stored results need a free slot; dropped fails never wait on the FIFO.
  always_comb begin
    store_s = {NUM_CH{1'b0}};
    elig_s  = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      store_s[i] = ch_passfail[i] | FWD_EN;
      if (store_s[i]) begin
        elig_s[i] = ch_valid[i] & ~fifo_full_s;
      end else begin
        elig_s[i] = ch_valid[i];
      end
    end
  end

  // Round-robin grant, suppressed while reset is asserted.
  always_comb begin
    elig_wide_s               = 16'h0000;
    elig_wide_s[NUM_CH-1:0]   = elig_s;
    grant_wide_s              = rrGrant(elig_wide_s, 4'(ptr_r), NUM_CH);
    if (reset) begin
      grant_s = {NUM_CH{1'b0}};
    end else begin
      grant_s = grant_wide_s[NUM_CH-1:0];
    end
  end

  // One-hot AND-OR mux of the granted channel's result.
  always_comb begin
    gnt_idx_s    = {LCH_BITS{1'b0}};
    push_entry_s = entry_t'({ENTRY_W{1'b0}});
    for (int i = 0; i < NUM_CH; i++) begin
      gnt_idx_s             = gnt_idx_s | (grant_s[i] ? LCH_BITS'(i) : {LCH_BITS{1'b0}});
      push_entry_s.passfail = push_entry_s.passfail | (grant_s[i] & ch_passfail[i]);
      push_entry_s.x        = push_entry_s.x | ({ROW_BITS{grant_s[i]}} & ch_x[i*ROW_BITS +: ROW_BITS]);
      push_entry_s.y        = push_entry_s.y | ({COL_BITS{grant_s[i]}} & ch_y[i*COL_BITS +: COL_BITS]);
      push_entry_s.scale    = push_entry_s.scale | ({SCALE_BITS{grant_s[i]}} & ch_scale[i*SCALE_BITS +: SCALE_BITS]);
    end
    push_entry_s.ch = gnt_idx_s;
  end

  assign ch_taken    = grant_s;
  assign xfer_s      = |grant_s;
  assign pass_xfer_s = |(grant_s & ch_passfail);
  assign push_s      = |(grant_s & store_s);
  assign pop_s       = out_valid & out_ready;
  assign fifo_full_s = (fifo_count_s == CNT_FULL);

  result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (push_entry_s),
    .dout  (head_s),
    .count (fifo_count_s),
    .full  (),
    .empty (fifo_empty_s)
  );

  // Round-robin pointer moves just past the granted channel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r <= {LCH_BITS{1'b0}};
    end else if (xfer_s) begin
      ptr_r <= (gnt_idx_s == CH_LAST) ? {LCH_BITS{1'b0}} : gnt_idx_s + CH_ONE;
    end else begin
      ptr_r <= ptr_r;
    end
  end

  // Saturating statistics; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_eval_r <= {CNT_BITS{1'b0}};
      cnt_pass_r <= {CNT_BITS{1'b0}};
    end else if (clear_stats) begin
      cnt_eval_r <= {CNT_BITS{1'b0}};
      cnt_pass_r <= {CNT_BITS{1'b0}};
    end else begin
      cnt_eval_r <= (xfer_s && cnt_eval_r != CNT_MAX) ? cnt_eval_r + CNT_ONE : cnt_eval_r;
      cnt_pass_r <= (pass_xfer_s && cnt_pass_r != CNT_MAX) ? cnt_pass_r + CNT_ONE : cnt_pass_r;
    end
  end

  assign out_valid     = ~fifo_empty_s;
  assign out_passfail  = head_s.passfail;
  assign out_x         = head_s.x;
  assign out_y         = head_s.y;
  assign out_scale     = head_s.scale;
  assign out_ch        = head_s.ch;
  assign cnt_evaluated = cnt_eval_r;
  assign cnt_passed    = cnt_pass_r;
  assign idle          = (fifo_count_s == {(PTR_BITS + 1){1'b0}}) & ~(|ch_valid);

endmodule

// File: tb/tb_processor_result_collector.sv
// Directed bench for processor_result_collector with 4 channels, 8-deep FIFO,
// fails dropped and 4-bit counters so saturation is reachable.
module tb_processor_result_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  ch_valid = 4'b0000;
  logic [3:0]  ch_passfail = 4'b0000;
  logic [39:0] ch_x = 40'd0;
  logic [39:0] ch_y = 40'd0;
  logic [15:0] ch_scale = 16'd0;
  logic [3:0]  ch_taken;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_passfail;
  logic [9:0]  out_x;
  logic [9:0]  out_y;
  logic [3:0]  out_scale;
  logic [1:0]  out_ch;
  logic        clear_stats = 1'b0;
  logic [3:0]  cnt_evaluated;
  logic [3:0]  cnt_passed;
  logic        idle;

  int tests  = 0;
  int failed = 0;

  processor_result_collector #(
    .NUM_CH(4), .DEPTH(8), .ROW_BITS(10), .COL_BITS(10), .SCALE_BITS(4),
    .FWD_FAILS(0), .CNT_BITS(4)
  ) dut (
    .clk(clk), .reset(reset), .ch_valid(ch_valid), .ch_passfail(ch_passfail),
    .ch_x(ch_x), .ch_y(ch_y), .ch_scale(ch_scale), .ch_taken(ch_taken),
    .out_valid(out_valid), .out_ready(out_ready), .out_passfail(out_passfail),
    .out_x(out_x), .out_y(out_y), .out_scale(out_scale), .out_ch(out_ch),
    .clear_stats(clear_stats), .cnt_evaluated(cnt_evaluated),
    .cnt_passed(cnt_passed), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic v, input logic pf, input int x, input int y, input int s);
    ch_valid[c]           = v;
    ch_passfail[c]        = pf;
    ch_x[c*10 +: 10]      = x[9:0];
    ch_y[c*10 +: 10]      = y[9:0];
    ch_scale[c*4 +: 4]    = s[3:0];
  endtask

  task automatic test_reset();
    reset = 1'b1; ch_valid = 4'b1111; ch_passfail = 4'b1111;
    tick();
    tests++; if (ch_taken !== 4'b0000) begin failed++; $display("FAIL reset_taken: got %b expected 0000", ch_taken); end
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    tests++; if (cnt_evaluated !== 4'd0 || cnt_passed !== 4'd0) begin failed++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", cnt_evaluated, cnt_passed); end
    tests++; if (out_x !== 10'd0 || out_ch !== 2'd0) begin failed++; $display("FAIL reset_out_data: got x=%0d ch=%0d expected 0/0", out_x, out_ch); end
    ch_valid = 4'b0000; #1;
    tests++; if (idle !== 1'b1) begin failed++; $display("FAIL reset_idle: got %b expected 1", idle); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_pass();
    set_ch(2, 1'b1, 1'b1, 5, 7, 3); #1;
    tests++; if (ch_taken !== 4'b0100) begin failed++; $display("FAIL single_taken: got %b expected 0100", ch_taken); end
    tick(); ch_valid = 4'b0000; #1;
    tests++; if (out_valid !== 1'b1) begin failed++; $display("FAIL single_out_valid: got %b expected 1", out_valid); end
    tests++; if (out_ch !== 2'd2 || out_x !== 10'd5 || out_y !== 10'd7 || out_scale !== 4'd3 || out_passfail !== 1'b1)
      begin failed++; $display("FAIL single_head: got ch=%0d x=%0d y=%0d s=%0d pf=%b expected 2/5/7/3/1", out_ch, out_x, out_y, out_scale, out_passfail); end
    tests++; if (cnt_passed !== 4'd1 || cnt_evaluated !== 4'd1) begin failed++; $display("FAIL single_counts: got %0d/%0d expected 1/1", cnt_evaluated, cnt_passed); end
    tests++; if (idle !== 1'b0) begin failed++; $display("FAIL single_not_idle: got %b expected 0", idle); end
    out_ready = 1'b1;
    tick(); out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0 || idle !== 1'b1) begin failed++; $display("FAIL single_drain: got valid=%b idle=%b expected 0/1", out_valid, idle); end
  endtask

  task automatic test_fail_drop();
    clear_stats = 1'b1; tick(); clear_stats = 1'b0;
    set_ch(1, 1'b1, 1'b0, 9, 9, 1); #1;
    tests++; if (ch_taken !== 4'b0010) begin failed++; $display("FAIL drop_taken: got %b expected 0010", ch_taken); end
    tick(); ch_valid = 4'b0000; #1;
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL drop_fifo_empty: got %b expected 0", out_valid); end
    tests++; if (cnt_evaluated !== 4'd1 || cnt_passed !== 4'd0) begin failed++; $display("FAIL drop_counts: got %0d/%0d expected 1/0", cnt_evaluated, cnt_passed); end
    tests++; if (idle !== 1'b1) begin failed++; $display("FAIL drop_idle: got %b expected 1", idle); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_t;
    reset = 1'b1; #1; reset = 1'b0; tick();
    for (int i = 0; i < 4; i++) set_ch(i, 1'b1, 1'b1, i, 0, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      exp_t = 4'b0001 << (k % 4); #1;
      tests++; if (ch_taken !== exp_t) begin failed++; $display("FAIL rr_grant_%0d: got %b expected %b", k, ch_taken, exp_t); end
      tick();
      set_ch(k % 4, 1'b1, 1'b1, k + 4, 0, 0);
      tests++; if (out_valid !== 1'b1 || out_x !== 10'(k) || out_ch !== 2'(k % 4))
        begin failed++; $display("FAIL rr_out_%0d: got v=%b x=%0d ch=%0d expected 1/%0d/%0d", k, out_valid, out_x, out_ch, k, k % 4); end
    end
    ch_valid = 4'b0000;
    tick();
    tests++; if (out_valid !== 1'b0 || cnt_evaluated !== 4'd8) begin failed++; $display("FAIL rr_end: got v=%b eval=%0d expected 0/8", out_valid, cnt_evaluated); end
    out_ready = 1'b0;
  endtask

  task automatic test_full_backpressure();
    clear_stats = 1'b1; tick(); clear_stats = 1'b0;
    for (int k = 0; k < 8; k++) begin
      set_ch(0, 1'b1, 1'b1, k, 0, 0); #1;
      tests++; if (ch_taken !== 4'b0001) begin failed++; $display("FAIL full_fill_%0d: got %b expected 0001", k, ch_taken); end
      tick();
    end
    set_ch(0, 1'b1, 1'b1, 99, 0, 0);
    set_ch(3, 1'b1, 1'b0, 33, 0, 0); #1;
    tests++; if (ch_taken !== 4'b1000) begin failed++; $display("FAIL full_fail_bypass: got %b expected 1000", ch_taken); end
    tick(); ch_valid[3] = 1'b0; #1;
    tests++; if (ch_taken !== 4'b0000) begin failed++; $display("FAIL full_hold: got %b expected 0000", ch_taken); end
    out_ready = 1'b1; #1;
    tests++; if (ch_taken !== 4'b0000 || out_x !== 10'd0) begin failed++; $display("FAIL full_same_cycle_pop: got taken=%b x=%0d expected 0000/0", ch_taken, out_x); end
    tick();
    tests++; if (ch_taken !== 4'b0001 || out_x !== 10'd1) begin failed++; $display("FAIL full_after_pop: got taken=%b x=%0d expected 0001/1", ch_taken, out_x); end
    tick(); ch_valid = 4'b0000;
    for (int k = 2; k < 8; k++) begin
      tests++; if (out_valid !== 1'b1 || out_x !== 10'(k)) begin failed++; $display("FAIL full_order_%0d: got v=%b x=%0d expected 1/%0d", k, out_valid, out_x, k); end
      tick();
    end
    tests++; if (out_valid !== 1'b1 || out_x !== 10'd99) begin failed++; $display("FAIL full_held_entry: got v=%b x=%0d expected 1/99", out_valid, out_x); end
    tick();
    tests++; if (out_valid !== 1'b0 || cnt_evaluated !== 4'd10 || cnt_passed !== 4'd9)
      begin failed++; $display("FAIL full_end: got v=%b eval=%0d pass=%0d expected 0/10/9", out_valid, cnt_evaluated, cnt_passed); end
    out_ready = 1'b0;
  endtask

  task automatic test_saturation_clear();
    clear_stats = 1'b1; tick(); clear_stats = 1'b0;
    out_ready = 1'b1;
    set_ch(0, 1'b1, 1'b1, 1, 0, 0);
    repeat (17) tick();
    tests++; if (cnt_passed !== 4'd15 || cnt_evaluated !== 4'd15) begin failed++; $display("FAIL sat_hold: got %0d/%0d expected 15/15", cnt_evaluated, cnt_passed); end
    clear_stats = 1'b1; #1;
    tests++; if (ch_taken !== 4'b0001) begin failed++; $display("FAIL sat_clear_xfer: got %b expected 0001", ch_taken); end
    tick(); clear_stats = 1'b0; ch_valid = 4'b0000;
    tests++; if (cnt_passed !== 4'd0 || cnt_evaluated !== 4'd0) begin failed++; $display("FAIL sat_clear_priority: got %0d/%0d expected 0/0", cnt_evaluated, cnt_passed); end
    tick(); tick();
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    for (int k = 0; k < 3; k++) begin
      set_ch(0, 1'b1, 1'b1, 10 + k, 0, 0); tick();
    end
    set_ch(0, 1'b1, 1'b1, 40, 0, 0);
    set_ch(2, 1'b1, 1'b1, 42, 0, 0);
    set_ch(3, 1'b1, 1'b1, 43, 0, 0);
    reset = 1'b1; #1;
    tests++; if (out_valid !== 1'b0 || ch_taken !== 4'b0000) begin failed++; $display("FAIL mreset_async: got v=%b taken=%b expected 0/0000", out_valid, ch_taken); end
    tick(); reset = 1'b0; #1;
    tests++; if (ch_taken !== 4'b0001) begin failed++; $display("FAIL mreset_first: got %b expected 0001", ch_taken); end
    tick(); ch_valid[0] = 1'b0; #1;
    tests++; if (out_valid !== 1'b1 || out_x !== 10'd40) begin failed++; $display("FAIL mreset_head: got v=%b x=%0d expected 1/40", out_valid, out_x); end
    tests++; if (ch_taken !== 4'b0100) begin failed++; $display("FAIL mreset_second: got %b expected 0100", ch_taken); end
    tick(); ch_valid[2] = 1'b0; #1;
    tests++; if (ch_taken !== 4'b1000) begin failed++; $display("FAIL mreset_third: got %b expected 1000", ch_taken); end
    tick(); ch_valid[3] = 1'b0; out_ready = 1'b1; #1;
    tests++; if (out_x !== 10'd40) begin failed++; $display("FAIL mreset_drain0: got %0d expected 40", out_x); end
    tick();
    tests++; if (out_x !== 10'd42) begin failed++; $display("FAIL mreset_drain1: got %0d expected 42", out_x); end
    tick();
    tests++; if (out_x !== 10'd43) begin failed++; $display("FAIL mreset_drain2: got %0d expected 43", out_x); end
    tick();
    tests++; if (out_valid !== 1'b0 || idle !== 1'b1) begin failed++; $display("FAIL mreset_empty: got v=%b idle=%b expected 0/1", out_valid, idle); end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_fail_drop();
    test_round_robin();
    test_full_backpressure();
    test_saturation_clear();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
